elevator_ctrl: RTL and testbench
================================

// Module: elevator_ctrl
// PURPOSE
//  N-floor elevator controller; successor to the 2-floor up/down FSM.
//  Latches per-floor call requests and serves them in SCAN order
//  (continue in current direction while calls remain ahead, then reverse).
//  Models floor-to-floor travel time and door dwell time with a timer.
//  Drives position/status outputs for the display and door logic.
// PARAMETERS
//  NUM_FLOORS     4   number of floors, >=2; floors are 0..NUM_FLOORS-1
//  TRAVEL_CYCLES  4   cycles in MOVE state per floor step, >=1
//  DOOR_CYCLES    3   cycles door_open stays high per stop, >=1
//  FLOOR_W        localparam = max(1,$clog2(NUM_FLOORS))
// PORTS
//  clk        in   1            clock, rising edge
//  reset      in   1            asynchronous, active-high
//  call_req   in   NUM_FLOORS   bit f high = call for floor f (level or pulse)
//  door_hold  in   1            held high in DOOR_OPEN = keep door open
//  floor      out  FLOOR_W      current floor
//  dir        out  1            1=up, 0=down; last/next travel direction
//  moving     out  1            high in MOVE_UP/MOVE_DOWN
//  door_open  out  1            high in DOOR_OPEN
//  arrive     out  1            1-cycle pulse on the edge a stop is made
//  pending    out  NUM_FLOORS   latched, unserved calls
// BEHAVIOUR
//  Reset (async, immediate, also mid-travel/mid-dwell): state=IDLE, floor=0,
//   dir=1, moving=0, door_open=0, arrive=0, pending=0, timer=0.
//  States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. Decisions use registered pending.
//  pending: each edge pending |= call_req, except the bit of the current
//   floor while in DOOR_OPEN (not latched; reloads door timer instead).
//   Bit cleared on the edge of arrival at that floor.
//  IDLE: pending[floor] -> DOOR_OPEN, clear bit, arrive=1. Else calls above
//   and below: go in dir. Only above -> MOVE_UP, dir=1. Only below ->
//   MOVE_DOWN, dir=0. None -> stay.
//  MOVE: entry loads timer=TRAVEL_CYCLES-1; decrement each cycle; on the edge
//   with timer==0 floor steps +/-1. Same edge: if pending[new floor] ->
//   DOOR_OPEN, clear bit, arrive=1; else continue (reload timer) while calls
//   remain ahead. Never step below 0 or above NUM_FLOORS-1.
//  DOOR_OPEN: entry loads timer=DOOR_CYCLES-1; call_req[floor] or door_hold
//   reloads it. On timer==0 edge: calls ahead in dir -> MOVE in dir; else
//   calls behind -> reverse dir, MOVE; else IDLE.
//  Latency: call at idle floor 0 sampled edge k -> moving after edge k+1.
//  All outputs registered or decoded directly from state/registers.
// STRUCTURE
//  elevator_pkg: state_t enum (2 bits), DIR_UP/DIR_DOWN constants.
//  Sub-module elev_req_scan (combinational): pending, floor -> any_above,
//   any_below, here; parametrised by NUM_FLOORS.
//  One shared down-counter for travel and door timing (never concurrent).
// TESTING  (NUM_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
//  1 Reset -> floor=0, dir=1, idle, all outputs 0; assert reset while moving
//    -> same values immediately, pending=0.
//  2 call_req=0100 one cycle at edge 1 -> pending=0100 after e1, moving after
//    e2, floor=1 after e6, floor=2+door_open+arrive after e10, idle after e13.
//  3 At floor 2 idle, call_req=1001 together -> dir=1: serve 3 first, then 0;
//    pending 1001->0001->0000, no stop at floor 1.
//  4 In DOOR_OPEN at floor 1, door_hold high 5 cycles -> door_open stays high,
//    closes DOOR_CYCLES cycles after door_hold drops.
//  5 Moving up 0->3, call floor 1 arrives before floor 1 step edge -> stops at
//    1; after that edge -> served on return only.
//  6 Call for current floor while idle -> door_open after next edge, no motion.

Source files
------------

// File: rtl/elevator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : elevator_pkg                                             |
// | Purpose   : Shared types and constants for the N-floor elevator      |
// |             controller (state encoding, direction values, helpers).  |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package elevator_pkg;

  // Controller state; 2-bit encoding with explicit values.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR_OPEN = 2'd3
  } state_t;

  // Direction encoding used on the dir output and internally.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Larger of two integers, for sizing the shared timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : elevator_pkg
`default_nettype wire

// File: rtl/elev_req_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : elev_req_scan                                            |
// | Purpose   : Combinational scan of the latched call vector relative   |
// |             to the current floor: calls above, calls below, and a    |
// |             call for the floor the car is standing on.               |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module elev_req_scan
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    floor,
  output logic                  any_above,
  output logic                  any_below,
  output logic                  here
);

  // Partition the pending vector around the current floor.
  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    here      = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(floor)) begin
        any_above = any_above | pending[i];
      end else if (i < int'(floor)) begin
        any_below = any_below | pending[i];
      end else begin
        here = pending[i];
      end
    end
  end

endmodule : elev_req_scan
`default_nettype wire

// File: rtl/elevator_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : elevator_ctrl                                            |
// | Purpose   : N-floor elevator controller. Latches per-floor calls and |
// |             serves them in SCAN order, modelling floor-to-floor      |
// |             travel time and door dwell time with one shared timer.   |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int  NUM_FLOORS    = 4,
  parameter int  TRAVEL_CYCLES = 4,
  parameter int  DOOR_CYCLES   = 3,
  localparam int FLOOR_W       = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] pending
);

  // Travel and door dwell never overlap, so one down-counter serves both.
  localparam int TIMER_MAX = max_int(TRAVEL_CYCLES, DOOR_CYCLES) - 1;
  localparam int TIMER_W   = (TIMER_MAX > 0) ? $clog2(TIMER_MAX + 1) : 1;

  localparam logic [TIMER_W-1:0]    TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0]    DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0]    TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [NUM_FLOORS-1:0] ONE_HOT0    = NUM_FLOORS'(1);

  state_t                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic                    dir_q, dir_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic                    arrive_q, arrive_d;

  logic                    any_above;
  logic                    any_below;
  logic                    here;

  logic [FLOOR_W-1:0]      floor_up;
  logic [FLOOR_W-1:0]      floor_dn;
  logic [NUM_FLOORS-1:0]   here_mask;
  logic [NUM_FLOORS-1:0]   up_mask;
  logic [NUM_FLOORS-1:0]   dn_mask;
  logic [NUM_FLOORS-1:0]   latch_mask;
  logic                    at_top;
  logic                    at_bottom;
  logic                    timer_zero;
  logic                    door_reload;
  logic                    go_up;
  logic                    go_down;

  // Where the calls lie relative to the current floor.
  elev_req_scan #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_scan (
    .pending   (pending_q),
    .floor     (floor_q),
    .any_above (any_above),
    .any_below (any_below),
    .here      (here)
  );

  assign floor_up   = floor_q + FLOOR_W'(1);
  assign floor_dn   = floor_q - FLOOR_W'(1);
  assign at_top     = (floor_q == TOP_FLOOR);
  assign at_bottom  = (floor_q == '0);
  assign here_mask  = ONE_HOT0 << floor_q;
  assign up_mask    = ONE_HOT0 << floor_up;
  assign dn_mask    = ONE_HOT0 << floor_dn;
  assign timer_zero = (timer_q == '0);

  // A call for the floor the door is open on is not latched; it only
  // keeps the door open, exactly like door_hold.
  assign latch_mask  = (state_q == ST_DOOR_OPEN) ? ~here_mask : '1;
  assign door_reload = door_hold | (|(call_req & here_mask));

  // Departure choice: keep the current direction while calls lie ahead,
  // otherwise turn toward the remaining calls.
  assign go_up   = any_above & ((dir_q == DIR_UP) | ~any_below);
  assign go_down = any_below & ~go_up;

  // Next-state, timer, position and call-latch logic.
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    arrive_d  = 1'b0;
    pending_d = pending_q | (call_req & latch_mask);

    case (state_q)
      ST_IDLE: begin
        if (here) begin
          state_d   = ST_DOOR_OPEN;
          timer_d   = DOOR_LOAD;
          arrive_d  = 1'b1;
          pending_d = pending_d & ~here_mask;
        end else if (go_up) begin
          state_d = ST_MOVE_UP;
          dir_d   = DIR_UP;
          timer_d = TRAVEL_LOAD;
        end else if (go_down) begin
          state_d = ST_MOVE_DOWN;
          dir_d   = DIR_DOWN;
          timer_d = TRAVEL_LOAD;
        end
      end

      ST_MOVE_UP: begin
        if (!timer_zero) begin
          timer_d = timer_q - TIMER_W'(1);
        end else if (at_top) begin
          // Cannot go higher; park rather than wrap.
          state_d = ST_IDLE;
        end else begin
          floor_d = floor_up;
          if ((pending_q & up_mask) != '0) begin
            state_d   = ST_DOOR_OPEN;
            timer_d   = DOOR_LOAD;
            arrive_d  = 1'b1;
            pending_d = pending_d & ~up_mask;
          end else if (any_above) begin
            // No stop at the new floor, so calls above it are exactly
            // the calls that were above the old floor.
            timer_d = TRAVEL_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_MOVE_DOWN: begin
        if (!timer_zero) begin
          timer_d = timer_q - TIMER_W'(1);
        end else if (at_bottom) begin
          state_d = ST_IDLE;
        end else begin
          floor_d = floor_dn;
          if ((pending_q & dn_mask) != '0) begin
            state_d   = ST_DOOR_OPEN;
            timer_d   = DOOR_LOAD;
            arrive_d  = 1'b1;
            pending_d = pending_d & ~dn_mask;
          end else if (any_below) begin
            timer_d = TRAVEL_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DOOR_OPEN: begin
        if (door_reload) begin
          timer_d = DOOR_LOAD;
        end else if (!timer_zero) begin
          timer_d = timer_q - TIMER_W'(1);
        end else if (go_up) begin
          state_d = ST_MOVE_UP;
          dir_d   = DIR_UP;
          timer_d = TRAVEL_LOAD;
        end else if (go_down) begin
          state_d = ST_MOVE_DOWN;
          dir_d   = DIR_DOWN;
          timer_d = TRAVEL_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset takes effect immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      floor_q   <= '0;
      dir_q     <= DIR_UP;
      timer_q   <= '0;
      pending_q <= '0;
      arrive_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      arrive_q  <= arrive_d;
    end
  end

  assign floor     = floor_q;
  assign dir       = dir_q;
  assign moving    = (state_q == ST_MOVE_UP) || (state_q == ST_MOVE_DOWN);
  assign door_open = (state_q == ST_DOOR_OPEN);
  assign arrive    = arrive_q;
  assign pending   = pending_q;

endmodule : elevator_ctrl
`default_nettype wire

// File: tb/tb_elevator_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_elevator_ctrl                                         |
// | Purpose   : Scoreboard bench for elevator_ctrl. An edge-counting     |
// |             behavioural model predicts every cycle's outputs and     |
// |             each stop; a monitor pops and compares on negedges.      |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tb_elevator_ctrl;

  localparam int NF = 4;
  localparam int TC = 4;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NF-1:0] call_req = '0;
  logic          door_hold = 1'b0;
  logic [1:0]    floor;
  logic          dir;
  logic          moving;
  logic          door_open;
  logic          arrive;
  logic [NF-1:0] pending;

  elevator_ctrl #(
    .NUM_FLOORS    (NF),
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .call_req  (call_req),
    .door_hold (door_hold),
    .floor     (floor),
    .dir       (dir),
    .moving    (moving),
    .door_open (door_open),
    .arrive    (arrive),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          fl;
    bit          dr;
    bit          mv;
    bit          dop;
    bit          arr;
    bit [NF-1:0] pend;
  } snap_t;

  snap_t exp_q[$];
  int    arr_q[$];
  int    n_checks = 0;
  int    n_err = 0;

  // Behavioural model: position as an integer, edges left until the next
  // floor step / door close, and the set of outstanding calls.
  int m_pos;
  bit m_up;
  bit m_moving;
  bit m_door;
  bit m_arr;
  bit m_calls[NF];
  int m_travel_left;
  int m_door_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit any_in(input bit c[NF], input int lo, input int hi);
    bit r = 1'b0;
    for (int i = lo; i <= hi; i++) r |= c[i];
    return r;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.fl  = m_pos;
    s.dr  = m_up;
    s.mv  = m_moving;
    s.dop = m_door;
    s.arr = m_arr;
    for (int i = 0; i < NF; i++) s.pend[i] = m_calls[i];
    return s;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_up = 1'b1; m_moving = 1'b0; m_door = 1'b0; m_arr = 1'b0;
    m_travel_left = 0; m_door_left = 0;
    for (int i = 0; i < NF; i++) m_calls[i] = 1'b0;
  endtask

  task automatic model_depart(input bit old[NF]);
    bit a = any_in(old, m_pos + 1, NF - 1);
    bit b = any_in(old, 0, m_pos - 1);
    if (a && (m_up || !b)) begin
      m_up = 1'b1; m_moving = 1'b1; m_travel_left = TC;
    end else if (b) begin
      m_up = 1'b0; m_moving = 1'b1; m_travel_left = TC;
    end
  endtask

  task automatic model_stop();
    m_calls[m_pos] = 1'b0;
    m_moving = 1'b0;
    m_door = 1'b1;
    m_door_left = DC;
    m_arr = 1'b1;
    arr_q.push_back(m_pos);
  endtask

  task automatic model_step(input logic [NF-1:0] c, input bit h);
    bit old[NF];
    old = m_calls;
    m_arr = 1'b0;
    for (int i = 0; i < NF; i++)
      if (c[i] && !(m_door && i == m_pos)) m_calls[i] = 1'b1;
    if (m_door) begin
      if (h || c[m_pos]) begin
        m_door_left = DC;
      end else begin
        m_door_left--;
        if (m_door_left == 0) begin
          m_door = 1'b0;
          model_depart(old);
        end
      end
    end else if (m_moving) begin
      m_travel_left--;
      if (m_travel_left == 0) begin
        m_pos += m_up ? 1 : -1;
        if (old[m_pos]) model_stop();
        else if (m_up ? any_in(old, m_pos + 1, NF - 1) : any_in(old, 0, m_pos - 1))
          m_travel_left = TC;
        else m_moving = 1'b0;
      end
    end else begin
      if (old[m_pos]) model_stop();
      else model_depart(old);
    end
    exp_q.push_back(model_snap());
  endtask

  // One clock cycle of stimulus; the model advances on the same edge.
  task automatic cycle(input logic [NF-1:0] c, input bit h);
    call_req  = c;
    door_hold = h;
    @(posedge clk);
    model_step(c, h);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    arr_q.delete();
    model_reset();
    exp_q.push_back(model_snap());
    #1;
    chk("rst_floor", floor, 0);
    chk("rst_dir", dir, 1);
    chk("rst_moving", moving, 0);
    chk("rst_door", door_open, 0);
    chk("rst_arrive", arrive, 0);
    chk("rst_pending", pending, 0);
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_until_arrive(input int exp_floor, input string name);
    int n = 0;
    do begin
      cycle('0, 1'b0);
      n++;
    end while (arrive !== 1'b1 && n < 60);
    chk({name, "_arrived"}, arrive, 1);
    chk({name, "_floor"}, floor, exp_floor);
  endtask

  task automatic run_until_idle(input string name);
    int n = 0;
    while ((moving !== 1'b0 || door_open !== 1'b0) && n < 80) begin
      cycle('0, 1'b0);
      n++;
    end
    chk({name, "_idle"}, {moving, door_open}, 0);
  endtask

  // Monitor: compares every cycle's predicted outputs, and each stop
  // against the queued stop floors.
  always @(negedge clk) begin
    snap_t s;
    if (exp_q.size() != 0) begin
      s = exp_q.pop_front();
      chk("floor", floor, s.fl);
      chk("dir", dir, s.dr);
      chk("moving", moving, s.mv);
      chk("door_open", door_open, s.dop);
      chk("arrive", arrive, s.arr);
      chk("pending", pending, s.pend);
      if (s.arr || arrive === 1'b1) begin
        if (arr_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL arrive_event: got arrive=%0b at floor %0d, no stop expected", arrive, floor);
        end else begin
          chk("arrive_floor", floor, arr_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [NF-1:0] rc;
    bit            rh;
    int            n;

    #1;
    do_reset();

    // Single call from idle at floor 0: exact timing of travel and dwell.
    cycle(4'b0100, 1'b0);
    chk("t2_pending_e1", pending, 4'b0100);
    chk("t2_still_idle_e1", moving, 0);
    cycle('0, 1'b0);
    chk("t2_moving_e2", moving, 1);
    repeat (3) cycle('0, 1'b0);
    chk("t2_floor_e5", floor, 0);
    cycle('0, 1'b0);
    chk("t2_floor_e6", floor, 1);
    repeat (4) cycle('0, 1'b0);
    chk("t2_floor_e10", floor, 2);
    chk("t2_door_e10", door_open, 1);
    chk("t2_arrive_e10", arrive, 1);
    repeat (2) cycle('0, 1'b0);
    chk("t2_door_e12", door_open, 1);
    cycle('0, 1'b0);
    chk("t2_idle_e13", {moving, door_open}, 0);
    chk("t2_pending_e13", pending, 0);

    // Calls both sides of floor 2 while heading up: 3 first, then 0.
    cycle(4'b1001, 1'b0);
    chk("t3_pending", pending, 4'b1001);
    chk("t3_dir", dir, 1);
    run_until_arrive(3, "t3_first");
    chk("t3_pending_mid", pending, 4'b0001);
    run_until_arrive(0, "t3_second");
    chk("t3_pending_end", pending, 0);
    run_until_idle("t3");

    // Call for the current floor while idle.
    cycle(4'b0001, 1'b0);
    chk("t6_no_door_yet", door_open, 0);
    cycle('0, 1'b0);
    chk("t6_door", door_open, 1);
    chk("t6_no_motion", moving, 0);
    chk("t6_floor", floor, 0);
    run_until_idle("t6");

    // door_hold keeps the door open; it closes DC cycles after release.
    cycle(4'b0010, 1'b0);
    run_until_arrive(1, "t4_stop");
    for (int i = 0; i < 5; i++) begin
      cycle('0, 1'b1);
      chk("t4_held_open", door_open, 1);
    end
    repeat (2) begin
      cycle('0, 1'b0);
      chk("t4_dwell_open", door_open, 1);
    end
    cycle('0, 1'b0);
    chk("t4_closed", door_open, 0);

    // Call for floor 1 placed before the floor-1 step edge: stop there.
    cycle(4'b0001, 1'b0);
    run_until_arrive(0, "t5a_home");
    run_until_idle("t5a_home");
    cycle(4'b1000, 1'b0);
    cycle('0, 1'b0);
    chk("t5a_moving", moving, 1);
    cycle(4'b0010, 1'b0);
    chk("t5a_not_stepped", floor, 0);
    run_until_arrive(1, "t5a_early_stop");
    run_until_arrive(3, "t5a_top");
    run_until_idle("t5a");

    // Call for floor 1 placed just after the floor-1 step edge: skipped
    // on the way up, served on the way back down.
    cycle(4'b0001, 1'b0);
    run_until_arrive(0, "t5b_home");
    run_until_idle("t5b_home");
    cycle(4'b1000, 1'b0);
    n = 0;
    do begin
      cycle('0, 1'b0);
      n++;
    end while (floor !== 2'd1 && n < 40);
    chk("t5b_at_floor1", floor, 1);
    cycle(4'b0010, 1'b0);
    run_until_arrive(3, "t5b_skip");
    chk("t5b_pending_at_top", pending, 4'b0010);
    run_until_arrive(1, "t5b_return");
    run_until_idle("t5b");

    // Reset asserted mid-travel.
    cycle(4'b1000, 1'b0);
    repeat (6) cycle('0, 1'b0);
    chk("t1_moving_before_reset", moving, 1);
    do_reset();

    // Random calls and holds, with periodic resets.
    for (int i = 0; i < 1500; i++) begin
      if (i % 500 == 499) begin
        do_reset();
      end else begin
        rc = ($urandom_range(0, 9) < 2) ? NF'($urandom_range(1, 15)) : '0;
        rh = ($urandom_range(0, 15) == 0);
        cycle(rc, rh);
      end
    end
    repeat (80) cycle('0, 1'b0);
    @(negedge clk);
    #1;
    chk("stop_queue_drained", arr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_elevator_ctrl
`default_nettype wire
